// File: rtl/mips_mem_pkg.sv
// Shared types for the memory port arbiter: FSM state and grant encodings,
// plus the default watchdog limit.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2,
      DONE    = 2'd3
   } arb_state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } grant_t;

   localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog for mem_port_arbiter; raises expired on the LIMIT-th
// consecutive run cycle since the last clear.
module mem_arb_watchdog #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   assign expired = run && (count == CW'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (run && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory port.
// Optional watchdog abort is compiled in with MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ready,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              stall_if,
   output logic              stall_dm,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              timeout_err
);

   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_BUSY_IF = BUSY_IF;
   localparam logic [1:0] ST_BUSY_DM = BUSY_DM;
   localparam logic [1:0] ST_DONE    = DONE;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0] state;
   grant_t     cur_grant;
   grant_t     last_grant;
   logic       pick_dm;
   logic       grant_now;
   logic       busy;
   logic       wd_expired;

   // On a tie the requester that lost the previous grant goes first.
   always_comb begin
      pick_dm = 1'b0;
      if (if_req && dm_req) begin
         pick_dm = (last_grant == GNT_IF);
      end else begin
         pick_dm = dm_req;
      end
   end

   assign grant_now = (state == ST_IDLE) && (if_req || dm_req);
   assign busy      = (state == ST_BUSY_IF) || (state == ST_BUSY_DM);

   assign if_ready = (state == ST_DONE) && (cur_grant == GNT_IF);
   assign dm_ready = (state == ST_DONE) && (cur_grant == GNT_DM);
   assign stall_if = if_req && !if_ready;
   assign stall_dm = dm_req && !dm_ready;

`ifdef MEM_ARB_TIMEOUT_EN
   logic timeout_q;

   mem_arb_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (grant_now),
      .run     (busy && !mem_ack),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= busy && !mem_ack && wd_expired;
      end
   end

   assign timeout_err = timeout_q;
`else
   assign wd_expired  = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Main FSM: grant in IDLE, hold the port until ack (or watchdog), then
   // spend one DONE cycle presenting the ready pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cur_grant  <= GNT_IF;
         last_grant <= GNT_IF;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_now) begin
                  mem_req <= 1'b1;
                  if (pick_dm) begin
                     state      <= ST_BUSY_DM;
                     cur_grant  <= GNT_DM;
                     last_grant <= GNT_DM;
                     mem_we     <= dm_we;
                     mem_addr   <= dm_addr;
                     mem_wdata  <= dm_wdata;
                  end else begin
                     state      <= ST_BUSY_IF;
                     cur_grant  <= GNT_IF;
                     last_grant <= GNT_IF;
                     mem_we     <= 1'b0;
                     mem_addr   <= if_addr;
                     mem_wdata  <= '0;
                  end
               end
            end
            ST_BUSY_IF, ST_BUSY_DM: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= ST_DONE;
                  if (cur_grant == GNT_DM) begin
                     dm_rdata <= mem_we ? '0 : mem_rdata;
                  end else begin
                     if_rdata <= mem_rdata;
                  end
               end else if (wd_expired) begin
                  mem_req <= 1'b0;
                  state   <= ST_DONE;
                  if (cur_grant == GNT_DM) begin
                     dm_rdata <= '0;
                  end else begin
                     if_rdata <= '0;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// transaction-level model compared against the DUT every cycle.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_ready;
   logic [DW-1:0] if_rdata;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic          dm_ready;
   logic [DW-1:0] dm_rdata;
   logic          stall_if;
   logic          stall_dm;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic          timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_ready    (if_ready),
      .if_rdata    (if_rdata),
      .dm_req      (dm_req),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_ready    (dm_ready),
      .dm_rdata    (dm_rdata),
      .stall_if    (stall_if),
      .stall_dm    (stall_dm),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for mem_req, lets it sit for n cycles, acking on the last.
   task automatic apply_stimulus(input int n, input logic [DW-1:0] rd);
      int i;
      for (i = 0; i < 20 && !mem_req; i++) step();
      if (!mem_req) begin
         check_output("mem_req_wait", {63'd0, mem_req}, 64'd1);
         return;
      end
      for (int j = 0; j < n - 1; j++) step();
      mem_ack   = 1'b1;
      mem_rdata = rd;
      step();
      mem_ack = 1'b0;
   endtask

   // Transaction-level model: cycle numbers of grant and completion decide
   // what every output must show in any given cycle.
   int            cyc = 0;
   bit            model_on = 1'b0;
   bit            active = 1'b0;
   bit            owner_dm = 1'b0;
   bit            last_dm = 1'b0;
   bit            timed_out = 1'b0;
   int            grant_cyc = 0;
   int            end_cyc = -1;
   logic [AW-1:0] x_addr = '0;
   logic          x_we = 1'b0;
   logic [DW-1:0] x_wdata = '0;
   logic [DW-1:0] x_if_rd = '0;
   logic [DW-1:0] x_dm_rd = '0;

   always @(negedge clk) begin
      bit done_now, x_req, x_if_rdy, x_dm_rdy;
      done_now = active && end_cyc >= 0 && cyc == end_cyc + 1;
      x_req    = active && cyc > grant_cyc && (end_cyc < 0 || cyc <= end_cyc);
      x_if_rdy = done_now && !owner_dm;
      x_dm_rdy = done_now && owner_dm;
      if (model_on) begin
         check_output("m_mem_req", {63'd0, mem_req}, {63'd0, x_req});
         check_output("m_if_ready", {63'd0, if_ready}, {63'd0, x_if_rdy});
         check_output("m_dm_ready", {63'd0, dm_ready}, {63'd0, x_dm_rdy});
         check_output("m_stall_if", {63'd0, stall_if}, {63'd0, if_req && !x_if_rdy});
         check_output("m_stall_dm", {63'd0, stall_dm}, {63'd0, dm_req && !x_dm_rdy});
         check_output("m_timeout_err", {63'd0, timeout_err}, {63'd0, done_now && timed_out});
         check_output("m_if_rdata", {32'd0, if_rdata}, {32'd0, x_if_rd});
         check_output("m_dm_rdata", {32'd0, dm_rdata}, {32'd0, x_dm_rd});
         if (x_req) begin
            check_output("m_mem_addr", {32'd0, mem_addr}, {32'd0, x_addr});
            check_output("m_mem_we", {63'd0, mem_we}, {63'd0, x_we});
            if (owner_dm) check_output("m_mem_wdata", {32'd0, mem_wdata}, {32'd0, x_wdata});
         end
      end
      if (rst) begin
         model_on = 1'b1;
         active   = 1'b0;
         last_dm  = 1'b0;
         x_if_rd  = '0;
         x_dm_rd  = '0;
      end else if (model_on) begin
         if (done_now) begin
            active = 1'b0;
         end else if (!active && (if_req || dm_req)) begin
            owner_dm  = (if_req && dm_req) ? !last_dm : dm_req;
            last_dm   = owner_dm;
            active    = 1'b1;
            timed_out = 1'b0;
            grant_cyc = cyc;
            end_cyc   = -1;
            x_addr    = owner_dm ? dm_addr : if_addr;
            x_we      = owner_dm ? dm_we : 1'b0;
            x_wdata   = dm_wdata;
         end else if (active && end_cyc < 0) begin
            if (mem_ack) begin
               end_cyc = cyc;
               if (owner_dm) x_dm_rd = x_we ? '0 : mem_rdata;
               else          x_if_rd = mem_rdata;
            end else if (TO_EN && (cyc - grant_cyc) == TO) begin
               end_cyc   = cyc;
               timed_out = 1'b1;
               if (owner_dm) x_dm_rd = '0;
               else          x_if_rd = '0;
            end
         end
      end
      cyc++;
   end

   initial begin
      int n;
      $display("[TB] start");
      repeat (3) step();
      rst = 1'b0;
      check_output("rst_mem_req", {63'd0, mem_req}, 64'd0);
      check_output("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
      check_output("rst_if_rdata", {32'd0, if_rdata}, 64'd0);
      check_output("rst_dm_ready", {63'd0, dm_ready}, 64'd0);

      // Single fetch, ack in the first mem_req cycle.
      if_req = 1'b1; if_addr = 32'h0000_0004;
      step();
      check_output("f_mem_req", {63'd0, mem_req}, 64'd1);
      check_output("f_mem_addr", {32'd0, mem_addr}, 64'h4);
      check_output("f_mem_we", {63'd0, mem_we}, 64'd0);
      mem_ack = 1'b1; mem_rdata = 32'h2002_0005;
      step();
      mem_ack = 1'b0;
      check_output("f_if_ready", {63'd0, if_ready}, 64'd1);
      check_output("f_if_rdata", {32'd0, if_rdata}, 64'h2002_0005);
      check_output("f_mem_req_low", {63'd0, mem_req}, 64'd0);
      if_req = 1'b0;
      step();
      check_output("f_if_ready_pulse", {63'd0, if_ready}, 64'd0);
      check_output("f_if_rdata_hold", {32'd0, if_rdata}, 64'h2002_0005);

      // Data write, ack in the fourth busy cycle.
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hCAFE_F00D;
      step();
      for (int i = 1; i <= 4; i++) begin
         check_output("w_mem_addr", {32'd0, mem_addr}, 64'h10);
         check_output("w_mem_wdata", {32'd0, mem_wdata}, 64'hCAFE_F00D);
         check_output("w_mem_we", {63'd0, mem_we}, 64'd1);
         if (i == 4) begin
            mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
         end
         step();
      end
      mem_ack = 1'b0;
      check_output("w_dm_ready", {63'd0, dm_ready}, 64'd1);
      check_output("w_dm_rdata", {32'd0, dm_rdata}, 64'd0);
      dm_req = 1'b0; dm_we = 1'b0;
      step();
      check_output("w_dm_ready_pulse", {63'd0, dm_ready}, 64'd0);

      // Ties after reset: DM, then IF, then DM again.
      rst = 1'b1; step(); rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h100;
      dm_req = 1'b1; dm_addr = 32'h200;
      step();
      check_output("tie1_dm_first", {32'd0, mem_addr}, 64'h200);
      apply_stimulus(1, 32'h1111_1111);
      check_output("tie1_dm_ready", {63'd0, dm_ready}, 64'd1);
      check_output("tie1_dm_rdata", {32'd0, dm_rdata}, 64'h1111_1111);
      dm_req = 1'b0;
      step(); step();
      check_output("tie1_if_next", {32'd0, mem_addr}, 64'h100);
      apply_stimulus(1, 32'h2222_2222);
      check_output("tie1_if_ready", {63'd0, if_ready}, 64'd1);
      if_addr = 32'h104; dm_req = 1'b1; dm_addr = 32'h204;
      step(); step();
      check_output("tie2_dm_again", {32'd0, mem_addr}, 64'h204);
      apply_stimulus(2, 32'h3333_3333);
      dm_req = 1'b0;
      apply_stimulus(1, 32'h4444_4444);
      check_output("tie2_if_rdata", {32'd0, if_rdata}, 64'h4444_4444);
      if_req = 1'b0;
      step();

      // Fetch request arriving mid data transfer waits for IDLE.
      dm_req = 1'b1; dm_addr = 32'h300;
      step();
      if_req = 1'b1; if_addr = 32'h400;
      step();
      check_output("busy_stall_if", {63'd0, stall_if}, 64'd1);
      check_output("busy_addr_kept", {32'd0, mem_addr}, 64'h300);
      apply_stimulus(3, 32'h5555_5555);
      check_output("busy_dm_ready", {63'd0, dm_ready}, 64'd1);
      dm_req = 1'b0;
      step(); step();
      check_output("busy_if_granted", {32'd0, mem_addr}, 64'h400);
      apply_stimulus(1, 32'h6666_6666);
      if_req = 1'b0;
      step();

      // Reset in BUSY_DM aborts the write; the requester then retries.
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h500; dm_wdata = 32'h1234_5678;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_output("rst_busy_mem_req", {63'd0, mem_req}, 64'd0);
      check_output("rst_busy_dm_ready", {63'd0, dm_ready}, 64'd0);
      apply_stimulus(1, 32'h7777_7777);
      check_output("retry_dm_ready", {63'd0, dm_ready}, 64'd1);
      dm_req = 1'b0; dm_we = 1'b0;
      step();

`ifdef MEM_ARB_TIMEOUT_EN
      // No ack: watchdog ends the fetch after TO busy cycles.
      if_req = 1'b1; if_addr = 32'h600;
      n = 0;
      for (int i = 0; i < 20 && !if_ready; i++) begin
         step();
         n++;
      end
      check_output("to_latency", n, 64'd9);
      check_output("to_err", {63'd0, timeout_err}, 64'd1);
      check_output("to_if_rdata", {32'd0, if_rdata}, 64'd0);
      if_req = 1'b0;
      step();
      check_output("to_err_pulse", {63'd0, timeout_err}, 64'd0);
`else
      n = 0;
`endif

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
